// File: rtl/ch4_pkg.sv
// ch4_pkg: shared types and constants for the noise-channel sequencer.
//   ch4_state_t   - channel FSM state (OFF / RUN)
//   LFSR_W        - width of the noise shift register
//   DIV_TIMER_W   - width of the polynomial-divider down-counter
//   ch4_div_base  - divisor code r -> base period in clk units (8, 16, 32 ... 112)
package ch4_pkg;

    typedef enum logic {
        OFF = 1'b0,
        RUN = 1'b1
    } ch4_state_t;

    localparam int LFSR_W      = 15;
    localparam int DIV_TIMER_W = 20;

    // r == 0 is the special half-size divisor; every other code is 16*r.
    function automatic logic [6:0] ch4_div_base(input logic [2:0] r);
        if (r == 3'd0) begin
            return 7'd8;
        end
        return {r, 4'b0000};
    endfunction

endpackage

// File: rtl/ch4_lfsr.sv
// ch4_lfsr: polynomial divider and noise LFSR for channel 4.
//   clk        - APU system clock
//   napu_reset - asynchronous active-low reset
//   en         - channel running; divider counts and LFSR may step
//   load       - trigger: reload divider and seed the LFSR (wins over en)
//   shift      - clock shift s (14/15 stop the divider)
//   width7     - 7-bit LFSR mode
//   div        - divisor code r
//   lfsr       - current LFSR contents
module ch4_lfsr
    import ch4_pkg::*;
#(
    parameter int                DIV_SCALE = 1,
    parameter logic [LFSR_W-1:0] LFSR_SEED = 15'h7FFF
) (
    input  logic              clk,
    input  logic              napu_reset,
    input  logic              en,
    input  logic              load,
    input  logic [3:0]        shift,
    input  logic              width7,
    input  logic [2:0]        div,
    output logic [LFSR_W-1:0] lfsr
);

    logic [DIV_TIMER_W-1:0] div_timer_q, div_timer_d;
    logic [LFSR_W-1:0]      lfsr_q, lfsr_d;
    logic [DIV_TIMER_W-1:0] reload;
    logic                   hold;

    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] v,
                                                     input logic              w7);
        logic              x;
        logic [LFSR_W-1:0] n;
        x = v[0] ^ v[1];
        n = {x, v[LFSR_W-1:1]};
        if (w7) begin
            n[6] = x;
        end
        return n;
    endfunction

    // Reload is sampled from the live FF22 fields, so a register change only
    // lands when the counter next wraps (or on trigger).
    assign reload = DIV_TIMER_W'(((32'(ch4_div_base(div)) << shift) * 32'(DIV_SCALE)) - 32'd1);
    assign hold   = (shift >= 4'd14);

    always_comb begin
        div_timer_d = div_timer_q;
        lfsr_d      = lfsr_q;
        if (load) begin
            div_timer_d = reload;
            lfsr_d      = LFSR_SEED;
        end else if (en && !hold) begin
            if (div_timer_q == '0) begin
                div_timer_d = reload;
                lfsr_d      = lfsr_step(lfsr_q, width7);
            end else begin
                div_timer_d = div_timer_q - DIV_TIMER_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge napu_reset) begin
        if (!napu_reset) begin
            div_timer_q <= '0;
            lfsr_q      <= LFSR_SEED;
        end else begin
            div_timer_q <= div_timer_d;
            lfsr_q      <= lfsr_d;
        end
    end

    assign lfsr = lfsr_q;

endmodule

// File: rtl/ch4_ctrl.sv
// ch4_ctrl: noise channel (channel 4) sequencer.
// Inputs : clk, napu_reset (async, active-low), tick_256hz / tick_64hz frame
//          sequencer enables, decoded FF20-FF23 fields (ff20_wr/ff20_len,
//          ff21_vol/up/period, ff22_shift/width7/div, ff23_trig/ff23_len_en).
// Outputs: ch4_restart (one-cycle pulse after a trigger), ch4_active,
//          ch4_vol (envelope volume), ch4_out (registered sample),
//          len_expired (length counter overflowed).
module ch4_ctrl
    import ch4_pkg::*;
#(
    parameter int                DIV_SCALE = 1,
    parameter logic [LFSR_W-1:0] LFSR_SEED = 15'h7FFF
) (
    input  logic       clk,
    input  logic       napu_reset,
    input  logic       tick_256hz,
    input  logic       tick_64hz,
    input  logic       ff20_wr,
    input  logic [5:0] ff20_len,
    input  logic [3:0] ff21_vol,
    input  logic       ff21_up,
    input  logic [2:0] ff21_period,
    input  logic [3:0] ff22_shift,
    input  logic       ff22_width7,
    input  logic [2:0] ff22_div,
    input  logic       ff23_trig,
    input  logic       ff23_len_en,
    output logic       ch4_restart,
    output logic       ch4_active,
    output logic [3:0] ch4_vol,
    output logic [3:0] ch4_out,
    output logic       len_expired
);

    ch4_state_t        state_q, state_d;
    logic [5:0]        len_cnt_q, len_cnt_d;
    logic              len_expired_q, len_expired_d;
    logic [3:0]        vol_q, vol_d;
    logic [2:0]        env_timer_q, env_timer_d;
    logic              restart_q;
    logic [3:0]        out_q, out_d;
    logic [LFSR_W-1:0] lfsr_w;
    logic              dac_on;
    logic              running;
    logic              len_wrap;

    function automatic logic [3:0] env_step(input logic [3:0] v, input logic up);
        if (up && v != 4'd15) begin
            return v + 4'd1;
        end
        if (!up && v != 4'd0) begin
            return v - 4'd1;
        end
        return v;
    endfunction

    assign dac_on  = (ff21_vol != 4'd0) || ff21_up;
    assign running = (state_q == RUN);

    // Length counter. A register write beats a trigger, which beats a tick;
    // the losing length action is simply dropped for that cycle.
    always_comb begin
        len_cnt_d     = len_cnt_q;
        len_expired_d = len_expired_q;
        len_wrap      = 1'b0;
        if (ff20_wr) begin
            len_cnt_d     = ff20_len;
            len_expired_d = 1'b0;
        end else if (ff23_trig) begin
            len_expired_d = 1'b0;
        end else if (tick_256hz && ff23_len_en && !len_expired_q) begin
            if (len_cnt_q == 6'd63) begin
                len_cnt_d     = 6'd0;
                len_expired_d = 1'b1;
                len_wrap      = 1'b1;
            end else begin
                len_cnt_d = len_cnt_q + 6'd1;
            end
        end
    end

    // Channel FSM. len_wrap is never set in a trigger cycle, so a trigger
    // alone decides the RUN/OFF outcome there.
    always_comb begin
        state_d = state_q;
        case (state_q)
            OFF: begin
                if (ff23_trig && dac_on) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!dac_on || len_wrap) begin
                    state_d = OFF;
                end
            end
            default: state_d = OFF;
        endcase
    end

    // Envelope: trigger reloads; ticks only act while running with a
    // non-zero period.
    always_comb begin
        vol_d       = vol_q;
        env_timer_d = env_timer_q;
        if (ff23_trig) begin
            vol_d       = ff21_vol;
            env_timer_d = ff21_period;
        end else if (running && tick_64hz && ff21_period != 3'd0) begin
            if (env_timer_q > 3'd1) begin
                env_timer_d = env_timer_q - 3'd1;
            end else begin
                env_timer_d = ff21_period;
                vol_d       = env_step(vol_q, ff21_up);
            end
        end
    end

    // Sample is registered from the current lfsr/vol, so it trails them by one cycle.
    always_comb begin
        out_d = 4'd0;
        if (running && !lfsr_w[0]) begin
            out_d = vol_q;
        end
    end

    always_ff @(posedge clk or negedge napu_reset) begin
        if (!napu_reset) begin
            state_q       <= OFF;
            len_cnt_q     <= 6'd0;
            len_expired_q <= 1'b0;
            vol_q         <= 4'd0;
            env_timer_q   <= 3'd0;
            restart_q     <= 1'b0;
            out_q         <= 4'd0;
        end else begin
            state_q       <= state_d;
            len_cnt_q     <= len_cnt_d;
            len_expired_q <= len_expired_d;
            vol_q         <= vol_d;
            env_timer_q   <= env_timer_d;
            restart_q     <= ff23_trig;
            out_q         <= out_d;
        end
    end

    ch4_lfsr #(
        .DIV_SCALE (DIV_SCALE),
        .LFSR_SEED (LFSR_SEED)
    ) u_lfsr (
        .clk        (clk),
        .napu_reset (napu_reset),
        .en         (running),
        .load       (ff23_trig),
        .shift      (ff22_shift),
        .width7     (ff22_width7),
        .div        (ff22_div),
        .lfsr       (lfsr_w)
    );

    assign ch4_restart = restart_q;
    assign ch4_active  = running;
    assign ch4_vol     = vol_q;
    assign ch4_out     = out_q;
    assign len_expired = len_expired_q;

endmodule

// File: tb/tb_ch4_ctrl.sv
module tb_ch4_ctrl;

    logic       clk;
    logic       napu_reset;
    logic       tick_256hz, tick_64hz;
    logic       ff20_wr;
    logic [5:0] ff20_len;
    logic [3:0] ff21_vol;
    logic       ff21_up;
    logic [2:0] ff21_period;
    logic [3:0] ff22_shift;
    logic       ff22_width7;
    logic [2:0] ff22_div;
    logic       ff23_trig, ff23_len_en;
    logic       ch4_restart, ch4_active, len_expired;
    logic [3:0] ch4_vol, ch4_out;

    int n_vec = 0;
    int n_bad = 0;

    ch4_ctrl dut (
        .clk         (clk),
        .napu_reset  (napu_reset),
        .tick_256hz  (tick_256hz),
        .tick_64hz   (tick_64hz),
        .ff20_wr     (ff20_wr),
        .ff20_len    (ff20_len),
        .ff21_vol    (ff21_vol),
        .ff21_up     (ff21_up),
        .ff21_period (ff21_period),
        .ff22_shift  (ff22_shift),
        .ff22_width7 (ff22_width7),
        .ff22_div    (ff22_div),
        .ff23_trig   (ff23_trig),
        .ff23_len_en (ff23_len_en),
        .ch4_restart (ch4_restart),
        .ch4_active  (ch4_active),
        .ch4_vol     (ch4_vol),
        .ch4_out     (ch4_out),
        .len_expired (len_expired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       wr;
        logic [5:0] len;
        logic       trig;
        logic       len_en;
        logic       t256;
        logic       t64;
        logic [3:0] vol;
        logic       up;
        logic [2:0] per;
        logic       e_rst;
        logic       e_act;
        logic [3:0] e_vol;
        logic       e_exp;
        logic [5:0] e_len;
    } vec_t;

    vec_t tbl [27];

    function automatic vec_t mk(input int wr, input int len, input int trig, input int len_en,
                                input int t256, input int t64, input int vol, input int up,
                                input int per, input int e_rst, input int e_act, input int e_vol,
                                input int e_exp, input int e_len);
        vec_t v;
        v.wr = 1'(wr);       v.len = 6'(len);   v.trig = 1'(trig);  v.len_en = 1'(len_en);
        v.t256 = 1'(t256);   v.t64 = 1'(t64);   v.vol = 4'(vol);    v.up = 1'(up);
        v.per = 3'(per);     v.e_rst = 1'(e_rst); v.e_act = 1'(e_act);
        v.e_vol = 4'(e_vol); v.e_exp = 1'(e_exp); v.e_len = 6'(e_len);
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    // Inputs are set while clk is low; outputs are read after the following falling edge.
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    // ---------------- behavioural reference ----------------
    function automatic logic [14:0] ref_step(input logic [14:0] v, input logic w7);
        logic [14:0] r;
        logic        fb;
        fb = v[0] ^ v[1];
        r = v >> 1;
        r[14] = fb;
        if (w7) r[6] = fb;
        return r;
    endfunction

    function automatic int div_period(input logic [2:0] r, input logic [3:0] s);
        int base;
        base = (r == 3'd0) ? 8 : 16 * int'(r);
        return base << s;
    endfunction

    int          m_len, m_vol, m_env, m_cnt, m_per, m_out;
    bit          m_exp, m_run, m_rst;
    logic [14:0] m_lfsr;

    task automatic model_reset();
        m_len = 0; m_vol = 0; m_env = 0; m_cnt = 0; m_per = 1; m_out = 0;
        m_exp = 0; m_run = 0; m_rst = 0; m_lfsr = 15'h7FFF;
    endtask

    // Advance the reference by one clock using the inputs currently driven.
    task automatic model_edge();
        bit dac;
        bit wrapped;
        int n_out;
        dac     = (ff21_vol != 4'd0) || ff21_up;
        wrapped = 0;
        n_out   = (m_run && !m_lfsr[0]) ? m_vol : 0;
        if (ff23_trig) begin
            m_vol  = int'(ff21_vol);
            m_env  = int'(ff21_period);
            m_lfsr = 15'h7FFF;
            m_cnt  = 0;
            m_per  = div_period(ff22_div, ff22_shift);
        end else if (m_run) begin
            if (tick_64hz && ff21_period != 3'd0) begin
                if (m_env > 1) m_env = m_env - 1;
                else begin
                    m_env = int'(ff21_period);
                    if (ff21_up) m_vol = (m_vol < 15) ? m_vol + 1 : 15;
                    else         m_vol = (m_vol > 0) ? m_vol - 1 : 0;
                end
            end
            if (ff22_shift < 4'd14) begin
                if (m_cnt == m_per - 1) begin
                    m_lfsr = ref_step(m_lfsr, ff22_width7);
                    m_cnt  = 0;
                    m_per  = div_period(ff22_div, ff22_shift);
                end else m_cnt = m_cnt + 1;
            end
        end
        if (ff20_wr) begin
            m_len = int'(ff20_len); m_exp = 0;
        end else if (ff23_trig) begin
            m_exp = 0;
        end else if (tick_256hz && ff23_len_en && !m_exp) begin
            if (m_len == 63) begin m_len = 0; m_exp = 1; wrapped = 1; end
            else m_len = m_len + 1;
        end
        if (ff23_trig) m_run = dac;
        else if (!dac || wrapped) m_run = 0;
        m_rst = ff23_trig;
        m_out = n_out;
    endtask

    task automatic clear_inputs();
        tick_256hz = 0; tick_64hz = 0; ff20_wr = 0; ff20_len = 0;
        ff21_vol = 0; ff21_up = 0; ff21_period = 0;
        ff22_shift = 0; ff22_width7 = 0; ff22_div = 0;
        ff23_trig = 0; ff23_len_en = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        napu_reset = 1'b0;
        cyc();
        cyc();
        napu_reset = 1'b1;
        model_reset();
    endtask

    task automatic wait_step(output int k);
        logic [14:0] prev;
        prev = dut.u_lfsr.lfsr;
        k = 0;
        do begin
            cyc();
            k++;
        end while (dut.u_lfsr.lfsr == prev && k < 40);
    endtask

    initial begin
        int          k;
        int          mism, ones;
        logic [14:0] exp_l;
        bit          bits [254];

        clear_inputs();
        napu_reset = 1'b1;
        #2 napu_reset = 1'b0;
        #1;
        check("reset_outputs", 32'({ch4_restart, ch4_active, ch4_vol, ch4_out, len_expired}), 32'd0);
        check("reset_lfsr", 32'(dut.u_lfsr.lfsr), 32'h7FFF);
        check("reset_len", 32'(dut.len_cnt_q), 32'd0);
        @(negedge clk);
        do_reset();

        // ---------------- table-driven vectors (LFSR frozen by s = 14) ----------------
        //            wr len tr le t256 t64 vol up per | rst act vol exp len
        tbl[0]  = mk(0, 0,  0, 0, 0, 0, 10, 0, 0,   0, 0, 0,  0, 0);
        tbl[1]  = mk(0, 0,  1, 0, 0, 0, 10, 0, 0,   1, 1, 10, 0, 0);
        tbl[2]  = mk(0, 0,  0, 0, 0, 1, 10, 0, 0,   0, 1, 10, 0, 0);
        tbl[3]  = mk(0, 0,  0, 0, 0, 1, 10, 0, 0,   0, 1, 10, 0, 0);
        tbl[4]  = mk(1, 62, 0, 1, 0, 0, 10, 0, 0,   0, 1, 10, 0, 62);
        tbl[5]  = mk(0, 0,  0, 1, 1, 0, 10, 0, 0,   0, 1, 10, 0, 63);
        tbl[6]  = mk(0, 0,  0, 1, 1, 0, 10, 0, 0,   0, 0, 10, 1, 0);
        tbl[7]  = mk(0, 0,  0, 1, 1, 0, 10, 0, 0,   0, 0, 10, 1, 0);
        tbl[8]  = mk(0, 0,  1, 1, 0, 0, 10, 0, 0,   1, 1, 10, 0, 0);
        tbl[9]  = mk(1, 63, 0, 1, 1, 0, 10, 0, 0,   0, 1, 10, 0, 63);
        tbl[10] = mk(0, 0,  1, 1, 1, 0, 10, 0, 0,   1, 1, 10, 0, 63);
        tbl[11] = mk(0, 0,  0, 1, 1, 0, 10, 0, 0,   0, 0, 10, 1, 0);
        tbl[12] = mk(0, 0,  1, 1, 0, 0, 0,  0, 0,   1, 0, 0,  0, 0);
        tbl[13] = mk(0, 0,  1, 0, 0, 0, 14, 1, 1,   1, 1, 14, 0, 0);
        tbl[14] = mk(0, 0,  0, 0, 0, 1, 14, 1, 1,   0, 1, 15, 0, 0);
        tbl[15] = mk(0, 0,  0, 0, 0, 1, 14, 1, 1,   0, 1, 15, 0, 0);
        tbl[16] = mk(0, 0,  0, 0, 0, 1, 14, 1, 1,   0, 1, 15, 0, 0);
        tbl[17] = mk(0, 0,  1, 0, 0, 0, 2,  0, 2,   1, 1, 2,  0, 0);
        tbl[18] = mk(0, 0,  0, 0, 0, 1, 2,  0, 2,   0, 1, 2,  0, 0);
        tbl[19] = mk(0, 0,  0, 0, 0, 1, 2,  0, 2,   0, 1, 1,  0, 0);
        tbl[20] = mk(0, 0,  0, 0, 0, 1, 2,  0, 2,   0, 1, 1,  0, 0);
        tbl[21] = mk(0, 0,  0, 0, 0, 1, 2,  0, 2,   0, 1, 0,  0, 0);
        tbl[22] = mk(0, 0,  0, 0, 0, 1, 2,  0, 2,   0, 1, 0,  0, 0);
        tbl[23] = mk(0, 0,  0, 0, 0, 1, 2,  0, 2,   0, 1, 0,  0, 0);
        tbl[24] = mk(0, 0,  0, 0, 0, 0, 0,  0, 2,   0, 0, 0,  0, 0);
        tbl[25] = mk(0, 0,  0, 0, 0, 1, 5,  0, 0,   0, 0, 0,  0, 0);
        tbl[26] = mk(0, 0,  1, 0, 0, 1, 5,  0, 0,   1, 1, 5,  0, 0);

        ff22_shift = 4'd14;
        for (int i = 0; i < 27; i++) begin
            ff20_wr = tbl[i].wr;  ff20_len = tbl[i].len; ff23_trig = tbl[i].trig;
            ff23_len_en = tbl[i].len_en; tick_256hz = tbl[i].t256; tick_64hz = tbl[i].t64;
            ff21_vol = tbl[i].vol; ff21_up = tbl[i].up; ff21_period = tbl[i].per;
            cyc();
            check($sformatf("row%0d", i),
                  32'({ch4_restart, ch4_active, ch4_vol, len_expired, dut.len_cnt_q, ch4_out}),
                  32'({tbl[i].e_rst, tbl[i].e_act, tbl[i].e_vol, tbl[i].e_exp, tbl[i].e_len, 4'd0}));
        end
        clear_inputs();

        // ---------------- divider timing and LFSR modes ----------------
        do_reset();
        ff21_vol = 4'hF;
        ff23_trig = 1; cyc(); ff23_trig = 0;
        check("seed_on_trig", 32'(dut.u_lfsr.lfsr), 32'h7FFF);
        wait_step(k);
        check("first_step_delay_w15", 32'(k), 32'd8);
        check("lfsr_first_w15", 32'(dut.u_lfsr.lfsr), 32'h3FFF);

        ff22_width7 = 1;
        ff23_trig = 1; cyc(); ff23_trig = 0;
        wait_step(k);
        exp_l = ref_step(15'h7FFF, 1'b1);
        check("first_step_delay_w7", 32'(k), 32'd8);
        check("lfsr_first_w7", 32'(dut.u_lfsr.lfsr), 32'(exp_l));
        repeat (20 * 8) cyc();
        for (int i = 0; i < 20; i++) exp_l = ref_step(exp_l, 1'b1);
        for (int i = 0; i < 254; i++) begin
            repeat (8) cyc();
            bits[i] = dut.u_lfsr.lfsr[0];
            exp_l = ref_step(exp_l, 1'b1);
        end
        mism = 0; ones = 0;
        for (int i = 0; i < 127; i++) begin
            if (bits[i] != bits[i + 127]) mism++;
            if (bits[i]) ones++;
        end
        check("w7_period127", 32'(mism), 32'd0);
        check("w7_ones", 32'(ones), 32'd64);
        check("w7_lfsr_chain", 32'(dut.u_lfsr.lfsr), 32'(exp_l));
        ff22_shift = 4'd14;
        repeat (50) cyc();
        check("s14_hold", 32'(dut.u_lfsr.lfsr), 32'(exp_l));

        // ---------------- reset in the middle of a run ----------------
        do_reset();
        ff22_shift = 4'd3; ff22_div = 3'd5; ff21_vol = 4'd9;
        ff23_trig = 1; cyc(); ff23_trig = 0;
        repeat (300) cyc();
        check("pre_reset_active", 32'(ch4_active), 32'd1);
        #2 napu_reset = 1'b0; ff23_trig = 1;
        #1;
        check("midrun_reset_outputs", 32'({ch4_restart, ch4_active, ch4_vol, ch4_out, len_expired}), 32'd0);
        check("midrun_reset_lfsr", 32'(dut.u_lfsr.lfsr), 32'h7FFF);
        @(negedge clk);
        cyc();
        napu_reset = 1'b1; ff23_trig = 0;
        cyc();
        check("trig_lost_in_reset", 32'({ch4_restart, ch4_active}), 32'd0);
        ff23_trig = 1; cyc(); ff23_trig = 0;
        check("restart_after_reset", 32'({ch4_restart, ch4_active, ch4_vol}), 32'({1'b1, 1'b1, 4'd9}));
        cyc();
        check("restart_one_cycle", 32'({ch4_restart, ch4_active}), 32'({1'b0, 1'b1}));

        // ---------------- randomized run against the reference ----------------
        do_reset();
        ff21_vol = 4'd7; ff21_period = 3'd3; ff23_len_en = 1;
        for (int c = 0; c < 4000; c++) begin
            ff23_trig  = ($urandom_range(0, 399) == 0);
            ff20_wr    = ($urandom_range(0, 249) == 0);
            ff20_len   = 6'($urandom_range(56, 63));
            tick_256hz = ($urandom_range(0, 15) == 0);
            tick_64hz  = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 149) == 0) begin
                ff21_vol    = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
                ff21_up     = 1'($urandom_range(0, 1));
                ff21_period = 3'($urandom_range(0, 7));
            end
            if ($urandom_range(0, 299) == 0) begin
                ff22_shift  = 4'($urandom_range(0, 1));
                ff22_div    = 3'($urandom_range(0, 7));
                ff22_width7 = 1'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 99) == 0) ff23_len_en = ~ff23_len_en;
            model_edge();
            cyc();
            check($sformatf("rand_cyc%0d", c),
                  {ch4_restart, ch4_active, ch4_vol, ch4_out, len_expired, dut.len_cnt_q, dut.u_lfsr.lfsr},
                  {m_rst, m_run, 4'(m_vol), 4'(m_out), m_exp, 6'(m_len), m_lfsr});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
